// File: rtl/obi_cfg_initiator.sv
// Single-outstanding OBI manager turning local commands into config-port accesses.
// Define OBI_CFG_INITIATOR_TIMEOUT_EN to bound the wait for rvalid to TimeoutCycles.

package obi_cfg_initiator_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned IdWidth   = 4;

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic [IdWidth-1:0]     aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic                   req;
        obi_a_chan_t            a;
    } obi_req_t;

    typedef struct packed {
        logic [DataWidth-1:0]   rdata;
        logic                   err;
        logic [IdWidth-1:0]     rid;
    } obi_r_chan_t;

    typedef struct packed {
        logic                   gnt;
        logic                   rvalid;
        obi_r_chan_t            r;
    } obi_rsp_t;

endpackage

module obi_cfg_initiator
    import obi_cfg_initiator_pkg::*;
#(
    parameter type         obi_req_t     = obi_cfg_initiator_pkg::obi_req_t,
    parameter type         obi_rsp_t     = obi_cfg_initiator_pkg::obi_rsp_t,
    parameter int unsigned TimeoutCycles = 32'd256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [31:0]          cmd_addr_i,
    input  logic [31:0]          cmd_wdata_i,
    input  logic [3:0]           cmd_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output obi_req_t             obi_req_o,
    input  obi_rsp_t             obi_rsp_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t             state, state_next;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic [IdWidth-1:0] aid_q;
    logic [IdWidth-1:0] id_cnt;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic               resp_hit;
    logic               timeout_hit;

    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("obi_cfg_initiator: TimeoutCycles must be at least 2");
    end

    assign resp_hit = (state == RESP) && obi_rsp_i.rvalid;

`ifdef OBI_CFG_INITIATOR_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    // Counts RESP cycles; held at zero elsewhere so each RESP entry starts fresh.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (state == RESP) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign timeout_hit = (state == RESP) && !obi_rsp_i.rvalid &&
                         (tmo_cnt == TimeoutCycles - 32'd1);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (cmd_valid_i)                 state_next = REQ;
            REQ:  if (obi_rsp_i.gnt)               state_next = RESP;
            RESP: if (resp_hit || timeout_hit)     state_next = DONE;
            DONE: if (rsp_ready_i)                 state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            aid_q   <= '0;
            id_cnt  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid_i) begin
                we_q    <= cmd_we_i;
                addr_q  <= cmd_addr_i;
                wdata_q <= cmd_wdata_i;
                be_q    <= cmd_be_i;
                aid_q   <= id_cnt;
            end
            if (state == REQ && obi_rsp_i.gnt) begin
                id_cnt <= id_cnt + 1'b1;
            end
            // A mismatched rid still completes, but is flagged as an error.
            if (resp_hit) begin
                rdata_q <= we_q ? 32'd0 : obi_rsp_i.r.rdata;
                err_q   <= obi_rsp_i.r.err || (obi_rsp_i.r.rid != aid_q);
            end else if (timeout_hit) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        obi_req_o   = '0;
        cmd_ready_o = (state == IDLE);
        busy_o      = (state != IDLE);
        rsp_valid_o = (state == DONE);
        rsp_rdata_o = (state == DONE) ? rdata_q : 32'd0;
        rsp_err_o   = (state == DONE) && err_q;
        if (state == REQ) begin
            obi_req_o.req     = 1'b1;
            obi_req_o.a.addr  = addr_q;
            obi_req_o.a.we    = we_q;
            obi_req_o.a.be    = be_q;
            obi_req_o.a.wdata = wdata_q;
            obi_req_o.a.aid   = aid_q;
        end
    end

endmodule
